// File: rtl/calendar_counter.sv
// Binary calendar counter: advances sec..year on each tick and accepts a
// range-checked load of all six fields at once.
module calendar_counter #(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load_en,
  input  logic [5:0]  ld_sec,
  input  logic [5:0]  ld_min,
  input  logic [4:0]  ld_hour,
  input  logic [4:0]  ld_day,
  input  logic [3:0]  ld_month,
  input  logic [11:0] ld_year,
  output logic [5:0]  sec_bin,
  output logic [5:0]  min_bin,
  output logic [4:0]  hour_bin,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
  output logic [11:0] year_bin,
  output logic        leap,
  output logic        load_err,
  output logic        year_wrap
);

  localparam logic [11:0] YearMinC = 12'(YEAR_MIN);
  localparam logic [11:0] YearMaxC = 12'(YEAR_MAX);

  function automatic logic isLeap(input logic [11:0] year);
    logic div4, div100, div400;
    div4   = (year[1:0] == 2'd0);
    div100 = ((year % 12'd100) == 12'd0);
    div400 = ((year % 12'd400) == 12'd0);
    return div4 && (!div100 || div400);
  endfunction

  function automatic logic [4:0] daysInMonth(input logic [3:0] month, input logic leapYear);
    logic [4:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = leapYear ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [4:0]  hour_q, hour_d, day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;
  logic        loadErr_q, loadErr_d, yearWrap_q, yearWrap_d;

  logic [4:0]  curDays, ldDays;
  logic        loadValid;

  assign leap    = isLeap(year_q);
  assign curDays = daysInMonth(month_q, leap);
  // Day range of a load is judged against the date being loaded, not the current one.
  assign ldDays  = daysInMonth(ld_month, isLeap(ld_year));

  assign loadValid = (ld_sec <= 6'd59) && (ld_min <= 6'd59) && (ld_hour <= 5'd23)
                  && (ld_month >= 4'd1) && (ld_month <= 4'd12)
                  && (ld_day >= 5'd1) && (ld_day <= ldDays)
                  && (ld_year >= YearMinC) && (ld_year <= YearMaxC);

  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_d      = day_q;
    month_d    = month_q;
    year_d     = year_q;
    loadErr_d  = 1'b0;
    yearWrap_d = 1'b0;
    if (load_en) begin
      if (loadValid) begin
        sec_d   = ld_sec;
        min_d   = ld_min;
        hour_d  = ld_hour;
        day_d   = ld_day;
        month_d = ld_month;
        year_d  = ld_year;
      end else begin
        loadErr_d = 1'b1;
      end
    end else if (tick) begin
      if (sec_q != 6'd59) begin
        sec_d = sec_q + 6'd1;
      end else begin
        sec_d = 6'd0;
        if (min_q != 6'd59) begin
          min_d = min_q + 6'd1;
        end else begin
          min_d = 6'd0;
          if (hour_q != 5'd23) begin
            hour_d = hour_q + 5'd1;
          end else begin
            hour_d = 5'd0;
            if (day_q != curDays) begin
              day_d = day_q + 5'd1;
            end else begin
              day_d = 5'd1;
              if (month_q != 4'd12) begin
                month_d = month_q + 4'd1;
              end else begin
                month_d = 4'd1;
                if (year_q != YearMaxC) begin
                  year_d = year_q + 12'd1;
                end else begin
                  year_d     = YearMinC;
                  yearWrap_d = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      day_q      <= 5'd1;
      month_q    <= 4'd1;
      year_q     <= YearMinC;
      loadErr_q  <= 1'b0;
      yearWrap_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      loadErr_q  <= loadErr_d;
      yearWrap_q <= yearWrap_d;
    end
  end

  assign sec_bin   = sec_q;
  assign min_bin   = min_q;
  assign hour_bin  = hour_q;
  assign day_bin   = day_q;
  assign month_bin = month_q;
  assign year_bin  = year_q;
  assign load_err  = loadErr_q;
  assign year_wrap = yearWrap_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Directed bench for calendar_counter: hand-computed dates checked one cycle
// after each strobe.
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  ld_sec = '0;
  logic [5:0]  ld_min = '0;
  logic [4:0]  ld_hour = '0;
  logic [4:0]  ld_day = '0;
  logic [3:0]  ld_month = '0;
  logic [11:0] ld_year = '0;
  logic [5:0]  sec_bin, min_bin;
  logic [4:0]  hour_bin, day_bin;
  logic [3:0]  month_bin;
  logic [11:0] year_bin;
  logic        leap, load_err, year_wrap;

  int checks = 0;
  int failures = 0;

  calendar_counter #(.YEAR_MIN(2000), .YEAR_MAX(2999)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load_en(load_en),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
    .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
    .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin),
    .leap(leap), .load_err(load_err), .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] packDate(input int y, input int mo, input int d,
                                           input int h, input int mi, input int s);
    return {12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  // Drive one cycle of strobes at the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input logic doReset, input logic doTick, input logic doLoad,
                               input int y, input int mo, input int d,
                               input int h, input int mi, input int s);
    @(negedge clk);
    rst      = doReset;
    tick     = doTick;
    load_en  = doLoad;
    ld_year  = 12'(y);
    ld_month = 4'(mo);
    ld_day   = 5'(d);
    ld_hour  = 5'(h);
    ld_min   = 6'(mi);
    ld_sec   = 6'(s);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    tick    = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic loadDate(input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
    applyStimulus(1'b0, 1'b0, 1'b1, y, mo, d, h, mi, s);
  endtask

  task automatic tickOnce();
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic holdTick(input int cycles);
    @(negedge clk);
    tick = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [37:0] expDate,
                             input logic expLeap, input logic expErr, input logic expWrap);
    logic [37:0] obsDate;
    obsDate = {year_bin, month_bin, day_bin, hour_bin, min_bin, sec_bin};
    checks++;
    assert (obsDate === expDate) else begin
      failures++;
      $error("FAIL %s.date observed=%0d-%0d-%0d %0d:%0d:%0d expected=%0d-%0d-%0d %0d:%0d:%0d",
             tag, obsDate[37:26], obsDate[25:22], obsDate[21:17], obsDate[16:12],
             obsDate[11:6], obsDate[5:0], expDate[37:26], expDate[25:22],
             expDate[21:17], expDate[16:12], expDate[11:6], expDate[5:0]);
    end
    checks++;
    assert (leap === expLeap) else begin
      failures++;
      $error("FAIL %s.leap observed=%b expected=%b", tag, leap, expLeap);
    end
    checks++;
    assert (load_err === expErr) else begin
      failures++;
      $error("FAIL %s.load_err observed=%b expected=%b", tag, load_err, expErr);
    end
    checks++;
    assert (year_wrap === expWrap) else begin
      failures++;
      $error("FAIL %s.year_wrap observed=%b expected=%b", tag, year_wrap, expWrap);
    end
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);

    tickOnce();
    checkOutput("firstTick", packDate(2000, 1, 1, 0, 0, 1), 1'b1, 1'b0, 1'b0);

    holdTick(3);
    checkOutput("heldTick", packDate(2000, 1, 1, 0, 0, 4), 1'b1, 1'b0, 1'b0);

    loadDate(2023, 12, 31, 23, 59, 59);
    checkOutput("load2023", packDate(2023, 12, 31, 23, 59, 59), 1'b0, 1'b0, 1'b0);
    tickOnce();
    checkOutput("newYear2024", packDate(2024, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);

    loadDate(2100, 2, 28, 23, 59, 59);
    checkOutput("load2100", packDate(2100, 2, 28, 23, 59, 59), 1'b0, 1'b0, 1'b0);
    tickOnce();
    checkOutput("feb2100", packDate(2100, 3, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0);

    loadDate(2000, 2, 28, 23, 59, 59);
    tickOnce();
    checkOutput("feb2000to29", packDate(2000, 2, 29, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    loadDate(2000, 2, 29, 23, 59, 59);
    tickOnce();
    checkOutput("feb29toMar", packDate(2000, 3, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);

    loadDate(2050, 6, 30, 23, 59, 59);
    tickOnce();
    checkOutput("june30", packDate(2050, 7, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0);

    loadDate(2050, 6, 15, 10, 20, 59);
    tickOnce();
    checkOutput("minuteCarry", packDate(2050, 6, 15, 10, 21, 0), 1'b0, 1'b0, 1'b0);

    loadDate(2999, 12, 31, 23, 59, 59);
    checkOutput("load2999", packDate(2999, 12, 31, 23, 59, 59), 1'b0, 1'b0, 1'b0);
    tickOnce();
    checkOutput("yearWrap", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    idleCycle();
    checkOutput("wrapCleared", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);

    loadDate(2023, 2, 29, 12, 0, 0);
    checkOutput("rejFeb29", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    idleCycle();
    checkOutput("errCleared", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    loadDate(2024, 5, 10, 12, 60, 0);
    checkOutput("rejMin60", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    loadDate(2024, 0, 10, 12, 0, 0);
    checkOutput("rejMonth0", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    loadDate(1999, 5, 10, 12, 0, 0);
    checkOutput("rejYear1999", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    loadDate(2024, 4, 31, 12, 0, 0);
    checkOutput("rejApr31", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    loadDate(2024, 4, 30, 24, 0, 0);
    checkOutput("rejHour24", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 2050, 6, 15, 10, 20, 30);
    checkOutput("loadWinsTick", packDate(2050, 6, 15, 10, 20, 30), 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("noLateAdvance", packDate(2050, 6, 15, 10, 20, 30), 1'b0, 1'b0, 1'b0);

    loadDate(2023, 2, 29, 0, 0, 0);
    checkOutput("rejBeforeRst", packDate(2050, 6, 15, 10, 20, 30), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2023, 2, 29, 0, 0, 0);
    checkOutput("rstBadLoad", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    loadDate(2050, 6, 15, 10, 20, 30);
    applyStimulus(1'b1, 1'b0, 1'b1, 2060, 8, 20, 5, 6, 7);
    checkOutput("rstGoodLoad", packDate(2000, 1, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
